// File: rtl/vga_cmd_uart_tx.sv
// Serializes one (column, row, char) text-write command as three back-to-back
// 8N1 UART frames, LSB first, for the VGA controller's UART receiver.
//
// state | meaning
// IDLE  | line high, ready for a command; range check happens on acceptance
// START | driving the start bit (low) of the current byte
// DATA  | driving data bit bit_q of the current byte
// STOP  | driving the stop bit (high); then next byte or back to IDLE
module vga_cmd_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int COLS         = 80,
  parameter int ROWS         = 30
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] col_i,
  input  logic [7:0] row_i,
  input  logic [7:0] char_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [8:0] COL_LIM = 9'(COLS);
  localparam logic [8:0] ROW_LIM = 9'(ROWS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [1:0]    idx_q;
  logic [7:0]    col_q, row_q, chr_q;
  logic          tx_q, done_q, err_q;
  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          cmd_bad;

  always_comb begin
    cur_byte = chr_q;
    case (idx_q)
      2'd0:    cur_byte = col_q;
      2'd1:    cur_byte = row_q;
      default: cur_byte = chr_q;
    endcase
  end

  assign bit_end = (baud_q == BAUD_LAST);
  assign cmd_bad = ({1'b0, col_i} >= COL_LIM) || ({1'b0, row_i} >= ROW_LIM);

  // tx is a flop so the serial line never glitches on state decode
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      chr_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            col_q <= col_i;
            row_q <= row_i;
            chr_q <= char_i;
            if (cmd_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q <= START;
              baud_q  <= '0;
              bit_q   <= '0;
              idx_q   <= '0;
              tx_q    <= 1'b0;
            end
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            tx_q    <= cur_byte[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (idx_q != 2'd2) begin
              idx_q   <= idx_q + 2'd1;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign tx_o        = tx_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: doc/vga_cmd_uart_tx.md
Name: vga_cmd_uart_tx

Overview:
- Host-side initiator for the text-write command protocol used by the VGA controller's UART receiver.
- Accepts one (column, row, ASCII) command over a valid/ready handshake.
- Serializes it as three back-to-back 8N1 UART frames in the order column, row, character, with each byte sent LSB first.
- Used as a stimulus generator in top-level loopback benches, and as the transmit half of a host bridge that drives the controller's rx_i pin.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200 baud, rounded).
- COLS, 80, number of valid text columns; column values >= COLS are rejected.
- ROWS, 30, number of valid text rows; row values >= ROWS are rejected.

Ports:
- clk_i  input  1  system clock (25 MHz pixel clock domain).
- rstn_i  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present on col_i/row_i/char_i.
- cmd_ready_o  output  1  block can accept a command this cycle.
- col_i  input  8  target column.
- row_i  input  8  target row.
- char_i  input  8  ASCII code to write.
- tx_o  output  1  UART serial line; idles high.
- busy_o  output  1  a command is being serialized.
- done_o  output  1  one-cycle pulse when the last stop bit completes.
- err_o  output  1  one-cycle pulse when a command is rejected for an out-of-range column or row.

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - Outputs: tx_o=1, cmd_ready_o=1, busy_o=0, done_o=0, err_o=0.
  - Internal state: FSM=IDLE; bit counter, baud counter and byte index cleared.
  - Reset asserted mid-frame forces tx_o high immediately, with no wait for a clock edge. The partial frame is abandoned and never resumed.
- FSM states: IDLE, START, DATA, STOP.
- Byte index (0..2) selects the shift source: col, then row, then char.
- Handshake:
  - A command transfers on the rising edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o equals (FSM==IDLE); it is registered, with no combinational path from cmd_valid_i.
  - While busy, cmd_valid_i is ignored and inputs are don't-care.
  - All three bytes are latched at acceptance.
- Range check at acceptance:
  - If col_i >= COLS or row_i >= ROWS, the command is consumed but not sent.
  - err_o pulses on the next cycle; the FSM stays IDLE, tx_o stays high, and cmd_ready_o stays 1.
- Accepted valid command:
  - Next cycle: FSM=START, tx_o=0, busy_o=1, cmd_ready_o=0, byte index=0.
- Bit timing:
  - Each bit (start, 8 data, stop) holds tx_o for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- DATA state: bit k of the current byte is driven during the k-th data bit slot, k=0..7.
- STOP state:
  - tx_o=1 for CLKS_PER_BIT cycles.
  - If byte index < 2: increment the index and go directly to START. There is no extra idle cycle between frames.
  - If byte index == 2: go to IDLE.
- Frame length: one command = 30 bits = 30*CLKS_PER_BIT cycles from first start-bit cycle to the end of the final stop bit (6510 cycles at defaults).
- On entering IDLE after byte 2:
  - done_o=1 for one cycle, busy_o=0, cmd_ready_o=1, all in the same cycle.
  - If cmd_valid_i is high in that cycle, the next command is accepted there. Its start bit begins the following cycle, so the minimum inter-command idle-high gap is 1 cycle.
- done_o and err_o are never asserted together.
- A rejected command never produces done_o.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; no overflow is possible.

Test Plan:
- Reset: hold rstn_i=0 for 5 cycles, then release -> tx_o=1, cmd_ready_o=1, busy_o=0, done_o=0, err_o=0; tx_o stays 1 for 1000 idle cycles.
- Single command col=0, row=0, char=0x41 -> tx_o low 1 cycle after acceptance.
  - Sampling mid-bit every 217 cycles gives 0,00000000,1 / 0,00000000,1 / 0,10000010,1.
  - done_o pulses exactly 6510 cycles after the first start-bit cycle.
- Back-to-back: cmd_valid_i held high with two commands (5,3,0x5A) then (79,29,0x7E).
  - The second is accepted on the done_o cycle; exactly 1 high idle cycle separates the frames.
  - The second command's three bytes decode correctly.
- Out of range: col=80, row=0 -> err_o pulse next cycle, tx_o never leaves 1, cmd_ready_o stays 1. Repeat with row=30 -> same response.
- Reset mid-operation: assert rstn_i during the DATA state of byte 1 -> tx_o=1 asynchronously and busy_o=0. After release, a new command (1,1,0x42) transmits cleanly from byte 0.
- Loopback: connect tx_o to top rx_i and send (0,0,0x41) -> pmod[7:0]=0xFF at the expected 'A' glyph pixel positions in the next frame.
